// File: rtl/aes_key_schedule.sv
// On-the-fly AES-128/AES-256 round-key generator with a valid/ready output stream.
// Define AES_KEYSCHED_ZEROIZE_EN to wipe all key material on the final handshake.
module aes_key_schedule #(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_start,
    input  logic                  keyLen,
    input  logic [KEY_WIDTH-1:0]  cipher_key,
    output logic                  key_idle,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic [DATA_WIDTH-1:0] round_key,
    output logic [DATA_WIDTH-1:0] prev_round_key,
    output logic [3:0]            rk_index,
    output logic                  rk_last
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_EMIT = 3'b010,
        S_STEP = 3'b100
    } state_t;

    // Forward S-box, entry 0 in the top byte so that entry b sits at bit offset 8*(255-b).
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_f(input logic [7:0] b);
        logic [10:0] pos;
        pos    = {~b, 3'b000};
        sbox_f = SBOX[pos +: 8];
    endfunction

    function automatic logic [31:0] subword_f(input logic [31:0] w);
        subword_f = {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon_f(input logic [3:0] n);
        case (n)
            4'd1:    rcon_f = 8'h01;
            4'd2:    rcon_f = 8'h02;
            4'd3:    rcon_f = 8'h04;
            4'd4:    rcon_f = 8'h08;
            4'd5:    rcon_f = 8'h10;
            4'd6:    rcon_f = 8'h20;
            4'd7:    rcon_f = 8'h40;
            4'd8:    rcon_f = 8'h80;
            4'd9:    rcon_f = 8'h1b;
            4'd10:   rcon_f = 8'h36;
            default: rcon_f = 8'h00;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] cur_q, prev_q, lo_q;
    logic [3:0]            idx_q;
    logic                  klen_q, last_q;

    logic                  accept_s, hs_s;
    logic [3:0]            next_idx_s;
    logic [31:0]           tw_s, t_s, w0_s, w1_s, w2_s, w3_s;
    logic [DATA_WIDTH-1:0] base_s, next_key_s;
    logic [7:0]            rc_s;
    logic                  rot_s, next_last_s;

    assign accept_s = (state_q == S_IDLE) && key_start;
    assign hs_s     = (state_q == S_EMIT) && rk_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (key_start) state_d = S_EMIT; else state_d = S_IDLE;
            S_EMIT:  if (hs_s && last_q) state_d = S_STEP; else state_d = S_EMIT;
            S_STEP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the one-hot state flops.
    always_comb begin
        key_idle = 1'b0;
        rk_valid = 1'b0;
        case (state_q)
            S_IDLE:  key_idle = 1'b1;
            S_EMIT:  rk_valid = 1'b1;
            S_STEP:  key_idle = 1'b0;
            default: key_idle = 1'b0;
        endcase
    end

    // Next round key: AES-256 uses rk_{i-2} as base and alternates rotate+Rcon / plain SubWord.
    always_comb begin
        next_idx_s = idx_q + 4'd1;
        tw_s       = cur_q[31:0];
        if (klen_q) begin
            base_s = prev_q;
            rot_s  = ~next_idx_s[0];
            rc_s   = next_idx_s[0] ? 8'h00 : rcon_f({1'b0, next_idx_s[3:1]});
        end else begin
            base_s = cur_q;
            rot_s  = 1'b1;
            rc_s   = rcon_f(next_idx_s);
        end
        t_s  = subword_f(rot_s ? {tw_s[23:0], tw_s[31:24]} : tw_s) ^ {rc_s, 24'h000000};
        w0_s = base_s[127:96] ^ t_s;
        w1_s = base_s[95:64]  ^ w0_s;
        w2_s = base_s[63:32]  ^ w1_s;
        w3_s = base_s[31:0]   ^ w2_s;
        if (klen_q && (idx_q == 4'd0)) begin
            next_key_s = lo_q;
        end else begin
            next_key_s = {w0_s, w1_s, w2_s, w3_s};
        end
        next_last_s = ((next_idx_s == 4'd10) && !klen_q) || ((next_idx_s == 4'd14) && klen_q);
    end

    // Key registers: load on start, shift on each handshake, optionally wipe on the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q  <= '0;
            prev_q <= '0;
            lo_q   <= '0;
            idx_q  <= 4'd0;
            klen_q <= 1'b0;
            last_q <= 1'b0;
        end else if (accept_s) begin
            cur_q  <= cipher_key[KEY_WIDTH-1 -: DATA_WIDTH];
            prev_q <= '0;
            lo_q   <= cipher_key[KEY_WIDTH-DATA_WIDTH-1 -: DATA_WIDTH];
            idx_q  <= 4'd0;
            klen_q <= keyLen;
            last_q <= 1'b0;
        end else if (hs_s && last_q) begin
            last_q <= 1'b0;
`ifdef AES_KEYSCHED_ZEROIZE_EN
            cur_q  <= '0;
            prev_q <= '0;
            lo_q   <= '0;
`endif
        end else if (hs_s) begin
            prev_q <= cur_q;
            cur_q  <= next_key_s;
            idx_q  <= next_idx_s;
            last_q <= next_last_s;
        end
    end

    assign round_key      = cur_q;
    assign prev_round_key = prev_q;
    assign rk_index       = idx_q;
    assign rk_last        = last_q;

endmodule
